vga_timing: RTL
===============

# vga_timing

Raster timing generator for the 640x480 @ 60 Hz VGA output, the stage directly upstream of the `address` stage. It derives a pixel tick from the system clock, scans horizontal and vertical counters, and presents `col_addr` and `row_addr` for the visible pixel. It also samples the 12-bit pixel word returned by the address/ROM path and drives the registered R/G/B, HS and VS pins.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pixel; legal values ≥ 3.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous reset, active low
- `din`  in  12  pixel word from the ROM path; {R[3:0], G[3:0], B[3:0]}
- `col_addr`  out  10  visible column, 0–639
- `row_addr`  out  9  visible row, 0–479
- `rdn`  out  1  active-low pixel-valid/read strobe; 0 while `col_addr`/`row_addr` address a visible pixel
- `r`, `g`, `b`  out  4 each  colour outputs
- `hs`, `vs`  out  1 each  sync outputs, active low
- `frame_start`  out  1  one-`clk` pulse at start of each frame

## Operation
- Divider `d` counts 0..CLK_DIV-1 and wraps. The pixel tick is asserted when `d == CLK_DIV-1`. All other registers change only on tick cycles, except `frame_start`.
- Horizontal counter `h` runs 0..799 and advances on each tick, wrapping 799→0.
- Vertical counter `v` runs 0..524. It advances only when `h` wraps, and wraps 524→0.
- Horizontal timing: sync region is h 0–95, back porch h 96–143, visible h 144–783, front porch h 784–799.
- Vertical timing: sync region is v 0–1, back porch v 2–34, visible v 35–514, front porch v 515–524.
- On a tick, stage 1 loads from the pre-advance (`h`, `v`):
  - visible = (144 ≤ h ≤ 783) and (35 ≤ v ≤ 514)
  - `rdn` = ~visible
  - `col_addr` = visible ? h−144 : 0
  - `row_addr` = visible ? v−35 : 0
  - `hs_p` = ~(h < 96)
  - `vs_p` = ~(v < 2)
- On the same tick, stage 2 loads, giving a one-pixel delay so colour and sync stay aligned:
  - {`r`,`g`,`b`} = (`rdn` == 0) ? `din` : 12'h000, using `rdn` before this tick's update
  - `hs` = `hs_p`
  - `vs` = `vs_p`
- `frame_start` is 1 for exactly the one tick cycle on which `h == 0` and `v == 0`, and 0 otherwise.
- Subtractions are done at 10 bits and truncated to the port width. No out-of-range value may ever be driven.

## Timing
- Reset values of all outputs while `rst_n` = 0:
  - `d`, `h`, `v` = 0
  - `col_addr`, `row_addr` = 0
  - `rdn` = 1
  - `hs`, `hs_p`, `vs`, `vs_p` = 1
  - `r`, `g`, `b` = 0
  - `frame_start` = 0
- Reset takes effect immediately with no clock required. Reset asserted mid-line or mid-frame abandons the scan; after release, scanning restarts at `h` = 0, `v` = 0.
- The first tick occurs on the CLK_DIV-th rising edge after reset release.
- Line period is 800·CLK_DIV clk; frame period is 420000·CLK_DIV clk.
- Downstream budget: the `address` stage registers once and the ROM reads synchronously. `din` must therefore be valid within CLK_DIV−1 clk after `col_addr`/`row_addr` change; CLK_DIV ≥ 3 guarantees this.
- `col_addr`/`row_addr` are held constant for a full pixel period (CLK_DIV clk).
- Colour lags the address by exactly one pixel period. `hs`/`vs` carry the same lag.
- When the line wrap and frame wrap coincide (h = 799, v = 524), the next tick has h = 0, v = 0 and asserts `frame_start`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 10 clk with `din` = 12'hFFF → `rdn` = 1, `hs` = `vs` = 1, `r`/`g`/`b` = 0, `col_addr` = `row_addr` = 0. Release → first tick at edge 4 (CLK_DIV = 4) with `frame_start` = 1.
- **Horizontal sync:** measure `hs` → low for 384 clk, period 3200 clk. `vs` → low for 6400 clk, period 1,680,000 clk.
- **First visible pixel:** on the tick with h = 144, v = 35 → `rdn` = 0, `col_addr` = 0, `row_addr` = 0. Last visible pixel → `col_addr` = 639, `row_addr` = 479, then `rdn` = 1.
- **Colour path:** drive `din` = 12'hA5C → next pixel `r` = A, `g` = 5, `b` = C. With `rdn` = 1 and the same `din` → `r`/`g`/`b` = 0.
- **Mid-frame reset:** pulse `rst_n` low for 2 clk at v = 200, h = 400 (asynchronously, between edges) → outputs reach reset values before the next edge. After release, `h`/`v` restart at 0.
- **Frame wrap:** run two frames → `frame_start` pulses are exactly 1,680,000 clk apart and each lasts 1 clk. The `col_addr` maximum seen is 639 and the `row_addr` maximum seen is 479.

Source files
------------

// File: rtl/vga_timing.sv
// 640x480 @ 60 Hz raster timing generator: pixel-tick divider, h/v scan counters,
// registered pixel address stage and a one-pixel-delayed colour/sync output stage.
module vga_timing #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] din,
    output logic [9:0]  col_addr,
    output logic [8:0]  row_addr,
    output logic        rdn,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
);

    localparam int DW = $clog2(CLK_DIV);

    localparam logic [9:0] H_SYNC_END  = 10'd96;
    localparam logic [9:0] H_VIS_START = 10'd144;
    localparam logic [9:0] H_VIS_END   = 10'd783;
    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] V_SYNC_END  = 10'd2;
    localparam logic [9:0] V_VIS_START = 10'd35;
    localparam logic [9:0] V_VIS_END   = 10'd514;
    localparam logic [9:0] V_LAST      = 10'd524;

    logic [DW-1:0] d;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          hs_p;
    logic          vs_p;

    logic          tick;
    logic          pre_tick;
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic [9:0]    col_diff;
    logic [9:0]    row_diff;

    always_comb begin
        tick     = (d == DW'(CLK_DIV - 1));
        pre_tick = (d == DW'(CLK_DIV - 2));
        h_last   = (h == H_LAST);
        v_last   = (v == V_LAST);
        visible  = (h >= H_VIS_START) && (h <= H_VIS_END) &&
                   (v >= V_VIS_START) && (v <= V_VIS_END);
        col_diff = h - H_VIS_START;
        row_diff = v - V_VIS_START;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= '0;
        end else if (tick) begin
            d <= '0;
        end else begin
            d <= d + DW'(1);
        end
    end

    // Vertical only steps on the horizontal wrap, so both wrap together at 799/524.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            h <= h_last ? 10'd0 : h + 10'd1;
            if (h_last) begin
                v <= v_last ? 10'd0 : v + 10'd1;
            end
        end
    end

    // Stage 1: address and raw sync from the pre-advance scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn      <= 1'b1;
            col_addr <= '0;
            row_addr <= '0;
            hs_p     <= 1'b1;
            vs_p     <= 1'b1;
        end else if (tick) begin
            rdn      <= ~visible;
            col_addr <= visible ? col_diff : 10'd0;
            row_addr <= visible ? row_diff[8:0] : 9'd0;
            hs_p     <= ~(h < H_SYNC_END);
            vs_p     <= ~(v < V_SYNC_END);
        end
    end

    // Stage 2: colour sampled with the previous pixel's strobe, sync delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else if (tick) begin
            r  <= rdn ? 4'h0 : din[11:8];
            g  <= rdn ? 4'h0 : din[7:4];
            b  <= rdn ? 4'h0 : din[3:0];
            hs <= hs_p;
            vs <= vs_p;
        end
    end

    // Registered a cycle early so the pulse coincides exactly with the tick cycle at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pre_tick && (h == 10'd0) && (v == 10'd0);
        end
    end

endmodule
